tls_intersection_ctrl: RTL and testbench

Two-direction intersection controller. It sequences a north-south (NS) and an east-west (EW) signal head with mutually exclusive greens and an all-red clearance phase. Pedestrian requests are latched and served by a protected WALK phase. All phase durations are programmable through a set-load interface, and the counters count in clock ticks ("seconds").

---
 rtl/tls_intersection_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tls_intersection_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tls_intersection_ctrl.sv
// Two-direction intersection controller: NS/EW heads, all-red clearance and a protected pedestrian WALK phase.
// Optional emergency preemption is built when EMERG_PREEMPT_EN is defined.
module tls_intersection_ctrl #(
  parameter int unsigned W      = 4,
  parameter int unsigned DEF_G  = 4,
  parameter int unsigned DEF_Y  = 2,
  parameter int unsigned DEF_AR = 1,
  parameter int unsigned DEF_WK = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic         stop,
  input  logic [W-1:0] G_in,
  input  logic [W-1:0] Y_in,
  input  logic [W-1:0] AR_in,
  input  logic [W-1:0] WK_in,
  input  logic         ped_req,
`ifdef EMERG_PREEMPT_EN
  input  logic         emerg,
`endif
  output logic         ped_ack,
  output logic         ns_G,
  output logic         ns_Y,
  output logic         ns_R,
  output logic         ew_G,
  output logic         ew_Y,
  output logic         ew_R,
  output logic         walk
);

  typedef enum logic [2:0] {NS_G, NS_Y, ALL_R, WALK, EW_G, EW_Y} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic         next_ew, next_ew_n;
  logic         ped_pend, ped_pend_n;
  logic         ped_ack_n;
  logic [W-1:0] g_d, y_d, ar_d, wk_d;
  logic [W-1:0] g_n, y_n, ar_n, wk_n;
  logic [W-1:0] dur, dur_eff;
  logic         done;
  logic         run_normal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NS_G;
      cnt      <= ONE;
      next_ew  <= 1'b1;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
      g_d      <= W'(DEF_G);
      y_d      <= W'(DEF_Y);
      ar_d     <= W'(DEF_AR);
      wk_d     <= W'(DEF_WK);
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      next_ew  <= next_ew_n;
      ped_pend <= ped_pend_n;
      ped_ack  <= ped_ack_n;
      g_d      <= g_n;
      y_d      <= y_n;
      ar_d     <= ar_n;
      wk_d     <= wk_n;
    end
  end

  always_comb begin
    dur = g_d;
    unique case (state)
      NS_G, EW_G: dur = g_d;
      NS_Y, EW_Y: dur = y_d;
      ALL_R:      dur = ar_d;
      WALK:       dur = wk_d;
      default:    dur = g_d;
    endcase
    // A programmed zero still holds the phase for one tick.
    dur_eff = (dur == '0) ? ONE : dur;
    done    = (cnt >= dur_eff);
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    next_ew_n  = next_ew;
    ped_pend_n = ped_pend;
    ped_ack_n  = 1'b0;
    g_n        = g_d;
    y_n        = y_d;
    ar_n       = ar_d;
    wk_n       = wk_d;
    run_normal = 1'b0;

    if (set) begin
      g_n        = G_in;
      y_n        = Y_in;
      ar_n       = AR_in;
      wk_n       = WK_in;
      state_n    = NS_G;
      cnt_n      = ONE;
      next_ew_n  = 1'b1;
      ped_pend_n = 1'b0;
    end else begin
      if (ped_req && !ped_pend && state != WALK) begin
        ped_pend_n = 1'b1;
        ped_ack_n  = 1'b1;
      end
      if (!stop) begin
        run_normal = 1'b1;
`ifdef EMERG_PREEMPT_EN
        // Preemption overrides greens, clearance and walk; yellows still run to completion.
        if (emerg) begin
          unique case (state)
            NS_G:       begin state_n = NS_Y;  cnt_n = ONE; run_normal = 1'b0; end
            EW_G:       begin state_n = EW_Y;  cnt_n = ONE; run_normal = 1'b0; end
            ALL_R:      begin cnt_n = ONE; run_normal = 1'b0; end
            WALK:       begin state_n = ALL_R; cnt_n = ONE; run_normal = 1'b0; end
            default:    run_normal = 1'b1;
          endcase
        end
`endif
      end
    end

    if (run_normal) begin
      if (done) begin
        cnt_n = ONE;
        unique case (state)
          NS_G:  state_n = NS_Y;
          NS_Y:  begin state_n = ALL_R; next_ew_n = 1'b1; end
          EW_G:  state_n = EW_Y;
          EW_Y:  begin state_n = ALL_R; next_ew_n = 1'b0; end
          ALL_R: state_n = ped_pend ? WALK : (next_ew ? EW_G : NS_G);
          WALK:  begin
                   state_n    = next_ew ? EW_G : NS_G;
                   ped_pend_n = 1'b0;
                 end
          default: state_n = NS_G;
        endcase
      end else begin
        cnt_n = cnt + ONE;
      end
    end
  end

  always_comb begin
    ns_G = 1'b0; ns_Y = 1'b0; ns_R = 1'b0;
    ew_G = 1'b0; ew_Y = 1'b0; ew_R = 1'b0;
    walk = 1'b0;
    unique case (state)
      NS_G:    begin ns_G = 1'b1; ew_R = 1'b1; end
      NS_Y:    begin ns_Y = 1'b1; ew_R = 1'b1; end
      EW_G:    begin ew_G = 1'b1; ns_R = 1'b1; end
      EW_Y:    begin ew_Y = 1'b1; ns_R = 1'b1; end
      ALL_R:   begin ns_R = 1'b1; ew_R = 1'b1; end
      WALK:    begin ns_R = 1'b1; ew_R = 1'b1; walk = 1'b1; end
      default: begin ns_R = 1'b1; ew_R = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_tls_intersection_ctrl.sv
// Bench for tls_intersection_ctrl: directed steps plus random traffic against a phase/time-left reference model.
module tb_tls_intersection_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         set = 1'b0, stop = 1'b0, ped_req = 1'b0;
  logic [W-1:0] G_in = '0, Y_in = '0, AR_in = '0, WK_in = '0;
  logic         ped_ack, ns_G, ns_Y, ns_R, ew_G, ew_Y, ew_R, walk;
`ifdef EMERG_PREEMPT_EN
  logic         emerg = 1'b0;
`endif

  always #5 clk = ~clk;

  tls_intersection_ctrl #(.W(W), .DEF_G(4), .DEF_Y(2), .DEF_AR(1), .DEF_WK(3)) dut (
    .clk(clk), .reset(reset), .set(set), .stop(stop),
    .G_in(G_in), .Y_in(Y_in), .AR_in(AR_in), .WK_in(WK_in),
    .ped_req(ped_req),
`ifdef EMERG_PREEMPT_EN
    .emerg(emerg),
`endif
    .ped_ack(ped_ack),
    .ns_G(ns_G), .ns_Y(ns_Y), .ns_R(ns_R),
    .ew_G(ew_G), .ew_Y(ew_Y), .ew_R(ew_R), .walk(walk)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: current phase and ticks remaining in it.
  localparam int P_NSG = 0, P_NSY = 1, P_AR = 2, P_WALK = 3, P_EWG = 4, P_EWY = 5;
  int m_phase, m_left, m_toward_ew, m_pend, m_ack;
  int m_g, m_y, m_ar, m_wk;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int dur_of(input int p);
    case (p)
      P_NSG, P_EWG: return eff(m_g);
      P_NSY, P_EWY: return eff(m_y);
      P_AR:         return eff(m_ar);
      default:      return eff(m_wk);
    endcase
  endfunction

  // {ns_G, ns_Y, ns_R, ew_G, ew_Y, ew_R, walk}
  function automatic logic [6:0] lamps(input int p);
    case (p)
      P_NSG:   return 7'b100_001_0;
      P_NSY:   return 7'b010_001_0;
      P_EWG:   return 7'b001_100_0;
      P_EWY:   return 7'b001_010_0;
      P_AR:    return 7'b001_001_0;
      default: return 7'b001_001_1;
    endcase
  endfunction

  task automatic model_reset();
    m_g = 4; m_y = 2; m_ar = 1; m_wk = 3;
    m_phase = P_NSG; m_left = 4; m_toward_ew = 1; m_pend = 0; m_ack = 0;
  endtask

  task automatic model_step();
    int nxt, old_pend;
    if (set) begin
      m_g = int'(G_in); m_y = int'(Y_in); m_ar = int'(AR_in); m_wk = int'(WK_in);
      m_phase = P_NSG; m_left = eff(m_g); m_toward_ew = 1; m_pend = 0; m_ack = 0;
    end else begin
      old_pend = m_pend;
      m_ack = (ped_req && !m_pend && m_phase != P_WALK) ? 1 : 0;
      if (m_ack == 1) m_pend = 1;
      if (!stop) begin
        m_left--;
        if (m_left == 0) begin
          nxt = P_NSG;
          case (m_phase)
            P_NSG: nxt = P_NSY;
            P_NSY: begin nxt = P_AR; m_toward_ew = 1; end
            P_EWG: nxt = P_EWY;
            P_EWY: begin nxt = P_AR; m_toward_ew = 0; end
            P_AR:  nxt = old_pend ? P_WALK : (m_toward_ew ? P_EWG : P_NSG);
            default: begin nxt = m_toward_ew ? P_EWG : P_NSG; m_pend = 0; end
          endcase
          m_phase = nxt;
          m_left  = dur_of(nxt);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".lamps"}, {1'b0, ns_G, ns_Y, ns_R, ew_G, ew_Y, ew_R, walk}, {1'b0, lamps(m_phase)});
    chk({tag, ".ack"}, {7'b0, ped_ack}, 8'(m_ack));
    chk({tag, ".green_excl"}, {7'b0, ns_G & ew_G}, 8'd0);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare(tag);
  endtask

  task automatic load(input int g, input int y, input int ar, input int wk);
    G_in = W'(g); Y_in = W'(y); AR_in = W'(ar); WK_in = W'(wk);
    set = 1'b1;
    cycle("set");
    set = 1'b0;
  endtask

  initial begin
    #12;
    model_reset();
    compare("reset");
    reset = 1'b0;

    repeat (22) cycle("defaults");
    load(3, 1, 2, 2);
    repeat (14) cycle("short_seq");

    load(3, 1, 2, 2);
    ped_req = 1'b1;
    cycle("ped_pulse");
    ped_req = 1'b0;
    repeat (16) cycle("ped_serve");

    load(4, 2, 1, 3);
    cycle("pre_stop");
    stop = 1'b1;
    repeat (5) cycle("stop_hold");
    stop = 1'b0;
    repeat (6) cycle("post_stop");

    load(0, 2, 1, 2);
    ped_req = 1'b1;
    repeat (25) cycle("ped_held");
    ped_req = 1'b0;
    repeat (6) cycle("g_zero");

    for (int i = 0; i < 400; i++) begin
      ped_req = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        G_in = W'($urandom_range(0, 15)); Y_in = W'($urandom_range(0, 15));
        AR_in = W'($urandom_range(0, 15)); WK_in = W'($urandom_range(0, 15));
        set = 1'b1;
      end else begin
        set = 1'b0;
      end
      cycle("random");
    end
    set = 1'b0; stop = 1'b0; ped_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
